// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (sync, active-high); start/op/a/b launch an op;
//   hi_we/lo_we/wdata are mthi/mtlo writes; mf_req asks for HI/LO;
//   busy/done handshake; stall = mf_req & (busy | start); hi/lo outputs.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_step;
    logic               w_fix;
    logic               w_busy;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_nx;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_mag;
    logic [WIDTH-1:0]   w_rem_mag;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_wr_hi;
    logic               w_wr_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_fix    = 1'b0;
        w_busy   = 1'b0;
        unique case (r_state)
            S_IDLE: w_accept = start;
            S_RUN: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            S_FIX: begin
                w_fix  = 1'b1;
                w_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // op[0] set means unsigned; op[1] set means divide.
    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: high half is the partial remainder, low half
    // shifts the dividend out and the quotient bits in.
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_div_nx = w_diff[WIDTH]
        ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
        : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_quo_mag = r_acc[WIDTH-1:0];
    assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo     = r_neg_q ? -w_quo_mag : w_quo_mag;
    assign w_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div && r_dz) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else if (r_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    // start has priority over a same-cycle mthi/mtlo.
    assign w_wr_hi = (r_state == S_IDLE) && hi_we && !start;
    assign w_wr_lo = (r_state == S_IDLE) && lo_we && !start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_a     <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_cnt   <= '0;
                r_div   <= op[1];
                r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r <= w_signed && a[WIDTH-1];
                r_dz    <= (b == '0);
                r_a     <= a;
                r_opnd  <= op[1] ? w_abs_b : w_abs_a;
                r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= r_div ? w_div_nx : w_mul_nx;
            end
            if (w_fix) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_wr_hi) r_hi <= wdata;
                if (w_wr_lo) r_lo <= wdata;
            end
        end
    end

    assign busy  = w_busy;
    assign done  = r_done;
    assign stall = mf_req & (w_busy | start);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32).
// Directed spec cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         mf_req;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .mf_req(mf_req),
        .busy  (busy),
        .done  (done),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [63:0] p;
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'b00) begin
            p = 64'(sx * sy);
        end else if (o == 2'b01) begin
            p = {32'h0, x} * {32'h0, y};
        end else if (y == 0) begin
            p = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            p = {32'h0, 32'h8000_0000};
        end else if (o == 2'b10) begin
            p = {32'(sx % sy), 32'(sx / sy)};
        end else begin
            p = {x % y, x / y};
        end
        eh = p[63:32];
        el = p[31:0];
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input bit mf,
                          input bit disturb, input bit lo_wr);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        mf_req = mf;
        lo_we  = lo_wr;
        wdata  = 32'h5555_AAAA;
        #1;
        check("c0_stall", stall, mf);
        check("c0_busy", busy, 0);
        nxt();
        start = 1'b0;
        lo_we = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int c = 1; c <= W + 1; c++) begin
            if (disturb && c == 10) begin
                start = 1'b1;
                op    = ~o;
                a     = $urandom;
                b     = $urandom;
                hi_we = 1'b1;
                wdata = $urandom;
            end
            if (disturb && c == 11) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            #1;
            check($sformatf("busy_done_c%0d", c), {busy, done}, 2'b10);
            if (mf) check($sformatf("stall_c%0d", c), stall, 1);
            nxt();
        end
        #1;
        check("end_busy_done", {busy, done}, 2'b01);
        check("end_hi", hi, eh);
        check("end_lo", lo, el);
        if (mf) check("end_stall", stall, 0);
        mf_req = 1'b0;
        nxt();
        check("after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int           seen;

        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        mf_req = 1'b0;
        nxt();
        nxt();
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        mf_req = 1'b1;
        #1;
        check("rst_stall_idle", stall, 0);
        start = 1'b1;
        #1;
        check("rst_stall_start", stall, 1);
        nxt();
        start  = 1'b0;
        mf_req = 1'b0;
        reset  = 1'b0;
        #1;
        check("start_in_reset", busy, 0);
        nxt();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 32'h1234, 32'h0,
               32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        model(2'b00, 32'h0001_2345, 32'hFFFF_0003, eh, el);
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_0003, eh, el, 1'b1, 1'b1, 1'b0);

        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        nxt();
        hi_we = 1'b0;
        check("mthi", hi, 32'hDEAD_BEEF);
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        nxt();
        lo_we = 1'b0;
        check("mtlo", lo, 32'h0BAD_F00D);
        check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1357_9BDF;
        nxt();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("both_hi", hi, 32'h1357_9BDF);
        check("both_lo", lo, 32'h1357_9BDF);

        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);

        start = 1'b1;
        op    = 2'b00;
        a     = 32'h0F0F_1234;
        b     = 32'h8765_4321;
        nxt();
        start = 1'b0;
        repeat (14) nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        check("midrst_busy_done", {busy, done}, 2'b00);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            nxt();
        end
        check("midrst_no_done", seen, 0);
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 3 == 1) ry = ry >> 22;
            if (i % 4 == 2) rx = rx >> 16;
            if (i == 5) ry = '0;
            model(ro, rx, ry, eh, el);
            run_op(ro, rx, ry, eh, el, bit'(i % 2), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined processor. It is the successor to the single-shot multiplier that the controller drives via `start_mult`/`mult_sign`. It adds signed and unsigned divide, explicit HI/LO writes, a busy/done handshake and a stall request for `mfhi`/`mflo` that issue while an operation is in flight. It sits beside the EX-stage ALU, and its HI/LO outputs feed the writeback mux.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1, iteration counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; accepted only in IDLE.
- `op`  in  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `hi_we`  in  1  mthi write strobe.
- `lo_we`  in  1  mtlo write strobe.
- `wdata`  in  WIDTH  mthi/mtlo data.
- `mf_req`  in  1  an mfhi/mflo in the pipeline needs HI/LO this cycle.
- `busy`  out  1  operation in flight (registered).
- `done`  out  1  one-cycle pulse: HI/LO have just been updated with a result.
- `stall`  out  1  combinational; equals `mf_req & (busy | start)`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states are IDLE, RUN and FIX.
  - IDLE → RUN on `start`.
  - RUN → FIX when the counter reaches WIDTH iterations.
  - FIX → IDLE unconditionally.
- On accept, latch `op`. For signed ops latch |a| and |b| plus the sign flags. Clear the counter.
- Multiply uses radix-2 shift-add on the magnitudes: one bit per RUN cycle, producing a 2·WIDTH-bit product.
- Divide uses radix-2 restoring division on the magnitudes: one quotient bit per RUN cycle.
- FIX applies the sign correction and then writes HI/LO.
  - Signed mult: negate the 2·WIDTH product if sign(a)≠sign(b).
  - Signed div: quotient sign is sign(a)^sign(b); remainder sign follows a.
- Result mapping:
  - mult/multu: HI = product[2W-1:W], LO = product[W-1:0].
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero (b==0, detected at accept) takes the same latency. Result is LO = all ones, HI = a (original, unsigned view).
- Signed overflow (a = MIN, b = −1) produces LO = MIN, HI = 0. This falls out of the magnitude datapath truncated to WIDTH.
- `hi_we`/`lo_we` write `wdata` in IDLE only. Both may assert in the same cycle.
- `hi_we`/`lo_we` are ignored while `busy`.
- If `start` and `hi_we`/`lo_we` assert in the same IDLE cycle, `start` wins and the write is dropped.
- `start` while `busy` is ignored: no queueing, and the latched operands are unaffected.
- `reset` in any state:
  - Next state is IDLE; counter cleared.
  - `hi` = `lo` = 0, `busy` = 0, `done` = 0.
  - Any in-flight result is discarded.

## Timing
- Call the cycle in which `start` is sampled in IDLE "cycle 0".
- `busy` is high in cycles 1 … WIDTH+1. RUN occupies cycles 1 … WIDTH; FIX is cycle WIDTH+1.
- HI/LO take the result at the clock edge ending cycle WIDTH+1.
- In cycle WIDTH+2, `done` = 1, `busy` = 0 and the new HI/LO are visible. With WIDTH=32 this is cycle 34.
- Throughput: a new `start` may be accepted in the same cycle `done` pulses. Back-to-back issue is one op per WIDTH+2 cycles.
- `stall` is high from cycle 0 through WIDTH+1 whenever `mf_req` is high. It drops in the cycle `done` pulses, so the mfhi/mflo sees the new value.
- `hi_we`/`lo_we` in IDLE update `hi`/`lo` on the next edge.
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0. `stall` follows its inputs.

## Test plan
- **Unsigned multiply.** WIDTH=32, multu a=0xFFFF_FFFF, b=0xFFFF_FFFF → at cycle 34: HI=0xFFFF_FFFE, LO=0x0000_0001, `done` high for exactly one cycle, `busy` high cycles 1–33.
- **Signed multiply and divide.**
  - mult a=−7 (0xFFFF_FFF9), b=3 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
  - div a=−7, b=2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
  - divu a=100, b=7 → LO=14, HI=2.
- **Divide corner cases.**
  - divu a=0x1234, b=0 → LO=0xFFFF_FFFF, HI=0x1234, still at cycle 34.
  - div a=0x8000_0000, b=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- **Stall and writes while busy.** Hold `mf_req`=1 from cycle 0 → `stall`=1 in cycles 0–33 and 0 in cycle 34. Assert `start` with different operands and `hi_we` in cycle 10 → both ignored; HI/LO equal the first op's result.
- **HI/LO writes.** In IDLE, `hi_we`=1 with wdata=0xDEAD_BEEF → `hi`=0xDEAD_BEEF next cycle. `lo_we` and `start` in the same cycle → the op runs and LO is not written by wdata.
- **Reset mid-operation.** Assert `reset` at cycle 15 of a mult → next cycle `busy`=0 and HI=LO=0, with no `done` afterward. A new multu 6×7 then gives LO=42, HI=0 at its cycle 34.
